// File: rtl/counting_seq_gen.sv
// counting_seq_gen
//   Frame transmitter for 2-bit symbols. When a start request is accepted, it sends
//   LEAD idle symbols (00) and then REPS triplets of 01,10,11, one symbol per clock.
//   The hold input stalls the sequencer and freezes the symbol bus. All outputs are
//   registered.
//
// Parameters
//   LEAD   number of 00 symbols sent before the first triplet (0 allowed)
//   REPS   number of 01,10,11 triplets per frame (0 allowed)
//   CNT_W  width of the internal counters and of sym_cnt_o; LEAD and REPS < 2**CNT_W
//
// Ports
//   clk_i      rising-edge clock
//   reset_i    synchronous active-high reset
//   start_i    frame request; accepted only when idle and not held
//   hold_i     stall: freezes state, counters, num_o and sym_cnt_o while busy
//   num_o      current symbol
//   valid_o    num_o carries a newly emitted symbol this cycle
//   busy_o     frame in progress
//   done_o     one-cycle pulse after the last symbol of a frame
//   sym_cnt_o  symbols emitted in the current or last frame

module counting_seq_gen #(
   parameter int unsigned LEAD  = 2,
   parameter int unsigned REPS  = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             hold_i,
   output logic [1:0]       num_o,
   output logic             valid_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] sym_cnt_o
);

   // StArm is the cycle between the accepting edge and the first emitted symbol.
   // It also holds busy high for one cycle in a frame with no symbols at all.
   typedef enum logic [2:0] {
      StIdle,
      StArm,
      StLead,
      StP1,
      StP2,
      StP3,
      StFin
   } state_e;

   localparam logic [CNT_W-1:0] LeadC  = CNT_W'(LEAD);
   localparam logic [CNT_W-1:0] RepsC  = CNT_W'(REPS);
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   // State that follows the lead-in, and the first state of a frame.
   localparam state_e AfterLead = (REPS != 0) ? StP1 : StFin;
   localparam state_e FirstSt   = (LEAD != 0) ? StLead : AfterLead;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] lead_cnt_q, lead_cnt_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
   logic [1:0]       num_q, num_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Sequencer step control
   logic   step;  // the sequencer moves to nxt on this edge
   state_e nxt;   // state entered when the sequencer steps

   function automatic logic [1:0] sym_of(input state_e s);
      logic [1:0] sym;
      sym = 2'b00;
      unique case (s)
         StP1:    sym = 2'b01;
         StP2:    sym = 2'b10;
         StP3:    sym = 2'b11;
         default: sym = 2'b00;
      endcase
      return sym;
   endfunction

   always_comb begin
      state_d    = state_q;
      lead_cnt_d = lead_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      sym_cnt_d  = sym_cnt_q;
      num_d      = num_q;
      valid_d    = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      step       = 1'b0;
      nxt        = state_q;

      unique case (state_q)
         StIdle: begin
            if (start_i && !hold_i) begin
               state_d    = StArm;
               lead_cnt_d = '0;
               rep_cnt_d  = '0;
               sym_cnt_d  = '0;
               num_d      = 2'b00;
               busy_d     = 1'b1;
            end
         end
         StArm: begin
            step = !hold_i;
            nxt  = FirstSt;
         end
         StLead: begin
            // lead_cnt_q already includes the 00 currently on the bus.
            step = !hold_i;
            nxt  = (lead_cnt_q < LeadC) ? StLead : AfterLead;
         end
         StP1: begin
            step = !hold_i;
            nxt  = StP2;
         end
         StP2: begin
            step = !hold_i;
            nxt  = StP3;
         end
         StP3: begin
            step = !hold_i;
            nxt  = ((rep_cnt_q + CntOne) < RepsC) ? StP1 : StFin;
            if (step) begin
               rep_cnt_d = rep_cnt_q + CntOne;
            end
         end
         StFin: begin
            // hold is ignored here so the done pulse is never stretched.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            num_d   = 2'b00;
            busy_d  = 1'b0;
         end
      endcase

      if (step) begin
         state_d = nxt;
         if (nxt == StFin) begin
            num_d  = 2'b00;
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            num_d     = sym_of(nxt);
            valid_d   = 1'b1;
            sym_cnt_d = sym_cnt_q + CntOne;
            if (nxt == StLead) begin
               lead_cnt_d = lead_cnt_q + CntOne;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         lead_cnt_q <= '0;
         rep_cnt_q  <= '0;
         sym_cnt_q  <= '0;
         num_q      <= 2'b00;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lead_cnt_q <= lead_cnt_d;
         rep_cnt_q  <= rep_cnt_d;
         sym_cnt_q  <= sym_cnt_d;
         num_q      <= num_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign num_o     = num_q;
   assign valid_o   = valid_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign sym_cnt_o = sym_cnt_q;

   // Output relationships that must hold in every cycle outside reset.
   a_valid_busy: assert property (@(posedge clk_i) disable iff (reset_i)
      valid_o |-> busy_o);
   a_done_quiet: assert property (@(posedge clk_i) disable iff (reset_i)
      done_o |-> (!busy_o && !valid_o && num_o == 2'b00));
   a_done_pulse: assert property (@(posedge clk_i) disable iff (reset_i)
      done_o |=> !done_o);

endmodule

// File: tb/tb_counting_seq_gen.sv
module tb_counting_seq_gen;

   localparam int NDut = 4;
   localparam int unsigned LeadP [NDut] = '{2, 0, 0, 3};
   localparam int unsigned RepsP [NDut] = '{1, 2, 0, 2};

   localparam int MIdle   = 0;
   localparam int MActive = 1;
   localparam int MFin    = 2;

   logic       clk;
   logic       reset;
   logic       start;
   logic       hold;
   logic [1:0] num     [NDut];
   logic       valid   [NDut];
   logic       busy    [NDut];
   logic       done    [NDut];
   logic [7:0] sym_cnt [NDut];

   for (genvar g = 0; g < NDut; g++) begin : g_dut
      counting_seq_gen #(
         .LEAD  (LeadP[g]),
         .REPS  (RepsP[g]),
         .CNT_W (8)
      ) u_dut (
         .clk_i     (clk),
         .reset_i   (reset),
         .start_i   (start),
         .hold_i    (hold),
         .num_o     (num[g]),
         .valid_o   (valid[g]),
         .busy_o    (busy[g]),
         .done_o    (done[g]),
         .sym_cnt_o (sym_cnt[g])
      );
   end

   // Reference model: frame phase plus symbols still to send.
   int          m_st    [NDut];
   int unsigned m_left  [NDut];
   int unsigned m_cnt   [NDut];
   int unsigned m_num   [NDut];
   int unsigned m_valid [NDut];
   int unsigned m_busy  [NDut];
   int unsigned m_done  [NDut];

   // Scoreboard: expected symbols of each accepted frame, in order.
   int unsigned exp_sym [NDut][$];

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int unsigned frame_len(input int k);
      return LeadP[k] + 3 * RepsP[k];
   endfunction

   task automatic chk(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", name, k, $time, act, exp);
      end
   endtask

   // Advance the model of DUT k over one clock edge, using the inputs applied.
   task automatic model_edge(input int k);
      int unsigned pos;
      if (reset) begin
         m_st[k]    = MIdle;
         m_left[k]  = 0;
         m_cnt[k]   = 0;
         m_num[k]   = 0;
         m_valid[k] = 0;
         m_busy[k]  = 0;
         m_done[k]  = 0;
         exp_sym[k].delete();
      end else begin
         case (m_st[k])
            MIdle: begin
               m_valid[k] = 0;
               m_done[k]  = 0;
               if (start && !hold) begin
                  m_st[k]   = MActive;
                  m_left[k] = frame_len(k);
                  m_cnt[k]  = 0;
                  m_busy[k] = 1;
                  m_num[k]  = 0;
                  for (int i = 0; i < int'(LeadP[k]); i++) exp_sym[k].push_back(0);
                  for (int r = 0; r < int'(RepsP[k]); r++) begin
                     exp_sym[k].push_back(1);
                     exp_sym[k].push_back(2);
                     exp_sym[k].push_back(3);
                  end
               end
            end
            MActive: begin
               if (hold) begin
                  m_valid[k] = 0;
               end else if (m_left[k] == 0) begin
                  m_st[k]    = MFin;
                  m_busy[k]  = 0;
                  m_done[k]  = 1;
                  m_valid[k] = 0;
                  m_num[k]   = 0;
               end else begin
                  pos        = frame_len(k) - m_left[k];
                  m_num[k]   = (pos < LeadP[k]) ? 0 : ((pos - LeadP[k]) % 3) + 1;
                  m_left[k]  = m_left[k] - 1;
                  m_cnt[k]   = m_cnt[k] + 1;
                  m_valid[k] = 1;
               end
            end
            default: begin
               m_st[k]   = MIdle;
               m_done[k] = 0;
            end
         endcase
      end
   endtask

   // Apply inputs, let one edge happen, update the model, move off the edge.
   task automatic step(input logic r, input logic s, input logic h);
      reset = r;
      start = s;
      hold  = h;
      @(posedge clk);
      for (int k = 0; k < NDut; k++) model_edge(k);
      #1;
   endtask

   // Monitor: samples on the falling edge and checks against model and scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            for (int k = 0; k < NDut; k++) begin
               chk("valid", k, 32'(valid[k]), m_valid[k]);
               chk("busy", k, 32'(busy[k]), m_busy[k]);
               chk("done", k, 32'(done[k]), m_done[k]);
               chk("sym_cnt", k, 32'(sym_cnt[k]), m_cnt[k]);
               if (valid[k]) begin
                  if (exp_sym[k].size() == 0) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL extra_symbol dut%0d @%0t: got num=%0d, expected no symbol",
                              k, $time, num[k]);
                  end else begin
                     chk("num", k, 32'(num[k]), exp_sym[k].pop_front());
                  end
               end else begin
                  chk("num_hold", k, 32'(num[k]), m_num[k]);
               end
               if (done[k]) begin
                  chk("frame_drained", k, exp_sym[k].size(), 0);
                  chk("frame_len", k, 32'(sym_cnt[k]), frame_len(k));
               end
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      hold  = 1'b0;
      step(1'b1, 1'b0, 1'b0);
      mon_en = 1'b1;
      step(1'b1, 1'b0, 1'b0);

      // Plain frame, no stalls.
      step(1'b0, 1'b1, 1'b0);
      repeat (13) step(1'b0, 1'b0, 1'b0);

      // Three stall edges right after the 01 symbol of the LEAD=2, REPS=1 frame.
      step(1'b0, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b1);
      repeat (14) step(1'b0, 1'b0, 1'b0);

      // start held high through busy and FIN cycles, then a fresh frame.
      repeat (8) step(1'b0, 1'b1, 1'b0);
      repeat (14) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      repeat (14) step(1'b0, 1'b0, 1'b0);

      // Reset while the LEAD=2, REPS=1 frame is in P2, then a full frame.
      step(1'b0, 1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      repeat (14) step(1'b0, 1'b0, 1'b0);

      // Hold in idle blocks start.
      step(1'b0, 1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30),
              ($urandom_range(0, 99) < 25));
      end
      repeat (16) step(1'b0, 1'b0, 1'b0);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/counting_seq_gen.md
Name: counting_seq_gen

Overview:
- Transmit-side counterpart of the 2-bit symbol sequence detector.
- On a start request, drives one frame of 2-bit symbols onto a symbol bus, one symbol per clock. The frame is a programmable run of idle symbols (00) followed by a programmable number of 01,10,11 triplets.
- Used as the stimulus source / link transmitter feeding detector-style receivers. A valid qualifier and a hold (stall) input let the receiver side pace the stream.

Parameters:
- LEAD, 2, number of 00 symbols sent before the first triplet (0 allowed)
- REPS, 1, number of 01,10,11 triplets per frame (0 allowed)
- CNT_W, 8, width of internal counters and of sym_cnt; LEAD and REPS must be < 2**CNT_W

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  frame request, sampled on clk
- hold  input  1  stall: freezes the sequencer and the symbol bus
- num  output  2  current symbol (registered)
- valid  output  1  num carries a newly emitted symbol this cycle (registered)
- busy  output  1  frame in progress (registered)
- done  output  1  one-cycle pulse after the last symbol of a frame (registered)
- sym_cnt  output  CNT_W  symbols emitted in the current/last frame (registered)

Behaviour:
- Reset (reset=1 at posedge, any state, including mid-frame):
  - state=IDLE; num=00, valid=0, busy=0, done=0, sym_cnt=0.
  - The frame in progress is abandoned, with no done pulse.
- States: IDLE, LEAD, P1 (01), P2 (10), P3 (11), FIN. Internal counters lead_cnt and rep_cnt are CNT_W bits wide.
- Frame acceptance:
  - start is accepted only in IDLE with hold=0. It is ignored, not latched, when busy or when hold=1.
  - At the accepting edge: sym_cnt cleared to 0, lead_cnt=0, rep_cnt=0, busy=1.
  - Next state is LEAD if LEAD>0, else P1 if REPS>0, else FIN.
- Emission timing:
  - The symbol of the entered state appears on num at the same edge, with valid=1. Latency from start to first symbol is 1 edge.
  - LEAD emits 00. It stays in LEAD until LEAD symbols have been sent, then goes to P1, or to FIN if REPS=0.
  - P1 emits 01 -> P2. P2 emits 10 -> P3. P3 emits 11.
  - After P3, rep_cnt increments. If rep_cnt+1 < REPS the next state is P1, else FIN.
  - sym_cnt increments by 1 on every edge that emits a symbol (valid=1).
- FIN (entered at the edge after the last symbol):
  - num=00, valid=0, busy=0, done=1 for exactly that cycle.
  - Next edge: IDLE, done=0.
  - A start arriving in the FIN cycle is ignored.
- Degenerate frame (LEAD=0 and REPS=0): accepting edge -> FIN directly. No valid symbols, busy low again one cycle later, done pulses, sym_cnt=0.
- hold:
  - hold=1 at an edge while busy: state, counters, num and sym_cnt are unchanged; valid=0 for that cycle.
  - The next edge with hold=0 emits the next symbol, so no symbol is lost or duplicated.
  - hold has no effect in IDLE other than blocking start.
  - hold during FIN does not extend the done pulse.
- Idle outputs: num=00, valid=0, busy=0. sym_cnt keeps the count of the last frame until the next accepted start or reset.
- Frame length is LEAD + 3*REPS symbols. No counter wrap occurs within the legal parameter range.
- reset has priority over start and hold on the same edge.

Test Plan:
- LEAD=2, REPS=1, start pulse at edge 0, hold=0 -> edges 1..5 num=00,00,01,10,11 with valid=1. Edge 6: done=1, busy=0, sym_cnt=5. Edge 7: done=0.
- LEAD=0, REPS=2, start -> num=01,10,11,01,10,11 on 6 consecutive valid edges, then done. A detector fed only on valid cycles must raise its flag at the first 11.
- LEAD=2, REPS=1, hold=1 for 3 edges right after the 01 symbol -> num stays 01 with valid=0 for 3 cycles, then 10,11. done occurs 3 cycles later than the no-hold case; sym_cnt=5.
- start re-asserted while busy, and in the FIN cycle -> ignored; exactly one frame emitted; a new start in IDLE afterwards starts a fresh frame with sym_cnt reset.
- reset=1 at edge during P2 -> next cycle num=00, valid=0, busy=0, done=0, sym_cnt=0; no done pulse. A later start emits the full frame from the beginning.
- LEAD=0, REPS=0, start -> no valid cycles; done=1 one edge after acceptance; busy=1 for exactly one cycle.
